// File: rtl/coldata_pll_seq_pkg.sv
// COLDATA fPLL reset/lock sequencer: shared state encoding and timer sizing.
package coldata_pll_seq_pkg;

    localparam logic [2:0] PLL_RST_CODE   = 3'd0;
    localparam logic [2:0] WAIT_LOCK_CODE = 3'd1;
    localparam logic [2:0] STABILIZE_CODE = 3'd2;
    localparam logic [2:0] RUN_CODE       = 3'd3;

    typedef enum logic [2:0] {
        ST_PLL_RST   = PLL_RST_CODE,
        ST_WAIT_LOCK = WAIT_LOCK_CODE,
        ST_STABILIZE = STABILIZE_CODE,
        ST_RUN       = RUN_CODE
    } state_t;

    function automatic int timer_width(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
        int unsigned m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/coldata_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into refclk.
module coldata_sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/coldata_pll_reset_seq.sv
// COLDATA fPLL reset/lock sequencer on the free-running refclk.
// Lock-loss/retry counters are built only with COLDATA_PLL_SEQ_LOSS_CNT_EN.
module coldata_pll_reset_seq
    import coldata_pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 125000,
    parameter int unsigned CNT_W               = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             coldata_rst,
    output logic             ready,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int TW = timer_width(PLL_RST_CYCLES,
                                    LOCK_STABLE_CYCLES,
                                    LOCK_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_RST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] T_STB = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_TO  = TW'(LOCK_TIMEOUT_CYCLES - 1);

    logic          locked_s;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pll_rst_q, pll_rst_d;
    logic          coldata_rst_q, coldata_rst_d;
    logic          ready_q, ready_d;

    coldata_sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= ST_PLL_RST;
            timer_q       <= '0;
            pll_rst_q     <= 1'b1;
            coldata_rst_q <= 1'b1;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pll_rst_q     <= pll_rst_d;
            coldata_rst_q <= coldata_rst_d;
            ready_q       <= ready_d;
        end
    end

    // A lock drop is tested before any terminal count so it always wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PLL_RST: begin
                if (timer_q == T_RST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) state_d = ST_STABILIZE;
                else if (timer_q == T_TO) state_d = ST_PLL_RST;
            end
            ST_STABILIZE: begin
                if (!locked_s) state_d = ST_WAIT_LOCK;
                else if (timer_q == T_STB) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_PLL_RST;
        endcase
        if (soft_reset) state_d = ST_PLL_RST;

        if (soft_reset || (state_d != state_q)) timer_d = '0;
        else if (timer_q == '1) timer_d = timer_q;
        else timer_d = timer_q + 1'b1;
    end

    always_comb begin
        pll_rst_d     = (state_d == ST_PLL_RST);
        coldata_rst_d = (state_d != ST_RUN);
        ready_d       = (state_d == ST_RUN);
    end

    assign pll_rst     = pll_rst_q;
    assign coldata_rst = coldata_rst_q;
    assign ready       = ready_q;
    assign state       = state_q;

`ifdef COLDATA_PLL_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_q, retry_q;
    logic             loss_inc, retry_inc;

    assign loss_inc  = !soft_reset && (state_q == ST_RUN) && !locked_s;
    assign retry_inc = !soft_reset && (state_q == ST_WAIT_LOCK) &&
                       !locked_s && (timer_q == T_TO);

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q  <= '0;
            retry_q <= '0;
        end else begin
            if (loss_inc && (loss_q != '1)) loss_q <= loss_q + 1'b1;
            if (retry_inc && (retry_q != '1)) retry_q <= retry_q + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;
`else
    assign lock_loss_cnt = '0;
    assign retry_cnt     = '0;
`endif

endmodule

// File: tb/tb_coldata_pll_reset_seq.sv
// Self-checking bench for coldata_pll_reset_seq against a cycle reference model.
module tb_coldata_pll_reset_seq;

    localparam int P    = 4;
    localparam int S    = 8;
    localparam int T    = 32;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = 31;
`ifdef COLDATA_PLL_SEQ_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          soft_reset = 1'b0;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic          coldata_rst;
    logic          ready;
    logic [2:0]    state;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0..3, elapsed cycles in phase, lock delay line
    int m_st = 0;
    int m_t = 0;
    int m_loss = 0;
    int m_retry = 0;
    bit dly[2] = '{1'b0, 1'b0};

    always #5 refclk = ~refclk;

    coldata_pll_reset_seq #(
        .PLL_RST_CYCLES      (P),
        .LOCK_STABLE_CYCLES  (S),
        .LOCK_TIMEOUT_CYCLES (T),
        .CNT_W               (CW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .soft_reset    (soft_reset),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .coldata_rst   (coldata_rst),
        .ready         (ready),
        .state         (state),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit l);
        bit ls;
        int nx;
        if (r) begin
            m_st = 0; m_t = 0; m_loss = 0; m_retry = 0;
            dly[0] = 1'b0; dly[1] = 1'b0;
            return;
        end
        ls = dly[1];
        dly[1] = dly[0];
        dly[0] = l;
        nx = m_st;
        if (m_st == 0 && m_t == P - 1) nx = 1;
        if (m_st == 1 && ls) nx = 2;
        if (m_st == 1 && !ls && m_t == T - 1) nx = 0;
        if (m_st == 2) nx = !ls ? 1 : (m_t == S - 1 ? 3 : 2);
        if (m_st == 3 && !ls) nx = 1;
        if (s) nx = 0;
        if (!s && m_st == 1 && nx == 0 && m_retry < CMAX) m_retry++;
        if (!s && m_st == 3 && nx == 1 && m_loss < CMAX) m_loss++;
        if (s || nx != m_st) m_t = 0;
        else if (m_t < TMAX) m_t++;
        m_st = nx;
    endtask

    task automatic step(input bit r, input bit s, input bit l);
        rst = r; soft_reset = s; pll_locked = l;
        @(posedge refclk);
        model_edge(r, s, l);
        #1;
        chk("state", state, m_st);
        chk("pll_rst", pll_rst, m_st == 0);
        chk("coldata_rst", coldata_rst, m_st != 3);
        chk("ready", ready, m_st == 3);
        chk("loss_cnt", lock_loss_cnt, CNT_EN ? m_loss : 0);
        chk("retry_cnt", retry_cnt, CNT_EN ? m_retry : 0);
    endtask

    initial begin
        int n;
        int cnt;
        int last_rise;
        int period;
        int cyc;
        bit prev;
        bit lk;
        logic [CW-1:0] sv_loss, sv_retry;

        // power-up
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        cnt = pll_rst ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            if (pll_rst) cnt++;
        end
        chk("pll_rst_len", cnt, P);
        n = 0;
        do begin step(0, 0, 1); n++; end while (!ready && n < 40);
        chk("lock_to_ready", n, 11);

        // lock loss in RUN
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        n = 0;
        do begin step(0, 0, 0); n++; end while (ready && n < 10);
        chk("loss_latency", n, 3);
        chk("loss_cnt_1", lock_loss_cnt, CNT_EN ? 1 : 0);
        n = 0;
        do begin step(0, 0, 1); n++; end while (!ready && n < 40);
        chk("relock", ready, 1);

        // glitch during STABILIZE at timer 5
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        n = 0;
        while (!(m_st == 2 && m_t == 5) && n < 40) begin
            step(0, 0, 1); n++;
        end
        chk("reach_stab5", m_st * 8 + m_t, 2 * 8 + 5);
        sv_loss = lock_loss_cnt;
        step(0, 0, 0);
        n = 1;
        do begin step(0, 0, 1); n++; end while (!ready && n < 40);
        chk("glitch_to_ready", n, 12);
        chk("glitch_uncounted", lock_loss_cnt, sv_loss);

        // soft reset in RUN
        sv_loss = lock_loss_cnt;
        sv_retry = retry_cnt;
        step(0, 1, 1);
        chk("soft_state", state, 0);
        chk("soft_pll_rst", pll_rst, 1);
        chk("soft_coldata_rst", coldata_rst, 1);
        chk("soft_loss_keep", lock_loss_cnt, sv_loss);
        chk("soft_retry_keep", retry_cnt, sv_retry);
        for (int i = 0; i < 20; i++) step(0, 0, 1);

        // lock loss saturation
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 5; i++) step(0, 0, 0);
            for (int i = 0; i < 16; i++) step(0, 0, 1);
        end
        chk("loss_sat", lock_loss_cnt, CNT_EN ? CMAX : 0);

        // no lock: periodic re-pulse and retry saturation
        last_rise = -1;
        period = 0;
        prev = pll_rst;
        for (int i = 0; i < 36 * 9 + 40; i++) begin
            step(0, 0, 0);
            if (pll_rst && !prev) begin
                if (last_rise >= 0 && period == 0) period = i - last_rise;
                last_rise = i;
            end
            prev = pll_rst;
        end
        chk("repulse_period", period, P + T);
        chk("retry_sat", retry_cnt, CNT_EN ? CMAX : 0);
        chk("nolock_coldata_rst", coldata_rst, 1);

        // randomized traffic
        step(1, 0, 0);
        lk = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) lk = ~lk;
            step(($urandom_range(0, 699) == 0),
                 ($urandom_range(0, 99) == 0), lk);
            cyc++;
        end
        chk("random_cycles", cyc, 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
